// File: rtl/wb_qbus_init.sv
`default_nettype none
// ============================================================================
// Module   : wb_qbus_init
// Purpose  : Wishbone slave to Q-bus initiator bridge. Each Wishbone request
//            is run as one Q-bus DATI/DATO(B) cycle: address phase, SYNC,
//            data phase, DIN/DOUT strobe until RPLY, then RPLY release and
//            a single-clock Wishbone acknowledge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TSET  phase setup/hold length in clocks (1..15)
//   TMO   RPLY timeout in clocks (16..65535), used only with the macro below
// Build option
//   WB_QBUS_INIT_TIMEOUT_EN  enables the RPLY timeout and wbs_err_o
// Ports
//   vm_clk_p, vm_rst_n        clock, asynchronous active-low reset
//   wbs_*                     Wishbone slave (cyc/stb/we/sel/adr/dat/ack/err)
//   qb_ad_o/qb_ad_oe/qb_ad_i  Q-bus AD drive value, enable, sampled value
//   qb_sync/din/dout/wtbt     Q-bus control strobes (active high)
//   qb_rply_i                 Q-bus RPLY, asynchronous to vm_clk_p
// ============================================================================
module wb_qbus_init #(
    parameter int TSET = 2,
    parameter int TMO  = 1023
) (
    input  logic        vm_clk_p,
    input  logic        vm_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [1:0]  wbs_sel_i,
    input  logic [15:0] wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    output logic [15:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [15:0] qb_ad_o,
    output logic        qb_ad_oe,
    input  logic [15:0] qb_ad_i,
    output logic        qb_sync,
    output logic        qb_din,
    output logic        qb_dout,
    output logic        qb_wtbt,
    input  logic        qb_rply_i
);

    // Elaboration-time guard against out-of-range parameters.
    if (TSET < 1 || TSET > 15 || TMO < 16 || TMO > 65535) begin : g_param_check
        $error("wb_qbus_init: TSET or TMO out of range");
    end

    localparam logic [3:0] c_TSET_LAST = 4'(TSET - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADR  = 3'd1,
        S_SYN  = 3'd2,
        S_DAT  = 3'd3,
        S_RUN  = 3'd4,
        S_END  = 3'd5,
        S_ACK  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q;
    logic [15:0] adr_q, dat_q, rdata_q;
    logic        we_q, byte_q;
    logic        rply_meta_q, srply_q;
    logic        rply_low_q;   // srply seen low since SYN: guards against a stale RPLY
    logic        abort_q;      // master dropped cyc mid-cycle: suppress ack/err
    logic        phase_done;

    assign phase_done = (phase_q == c_TSET_LAST);

`ifdef WB_QBUS_INIT_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TMO - 1);
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit;
    logic        err_q;
`endif

    // ---------------- next-state ----------------
    always_comb begin
        state_d = state_q;
`ifdef WB_QBUS_INIT_TIMEOUT_EN
        tmo_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (wbs_cyc_i && wbs_stb_i) state_d = S_ADR;
            S_ADR:   if (phase_done)             state_d = S_SYN;
            S_SYN:   if (phase_done)             state_d = S_DAT;
            S_DAT:   if (phase_done)             state_d = S_RUN;
            S_RUN:   if (srply_q && rply_low_q)  state_d = S_END;
            S_END:   if (!srply_q)               state_d = S_ACK;
            S_ACK:                               state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
`ifdef WB_QBUS_INIT_TIMEOUT_EN
        // Timeout overrides a reply arriving in the same clock.
        if ((state_q == S_RUN || state_q == S_END) && tmo_cnt_q == c_TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = S_IDLE;
        end
`endif
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 4'd0;
            adr_q       <= 16'h0000;
            dat_q       <= 16'h0000;
            rdata_q     <= 16'h0000;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            rply_meta_q <= 1'b0;
            srply_q     <= 1'b0;
            rply_low_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rply_meta_q <= qb_rply_i;
            srply_q     <= rply_meta_q;

            if (state_d != state_q)
                phase_q <= 4'd0;
            else if (state_q == S_ADR || state_q == S_SYN || state_q == S_DAT)
                phase_q <= phase_q + 4'd1;

            if (state_q == S_IDLE && state_d == S_ADR) begin
                // Upper-byte-only access addresses the odd byte.
                adr_q  <= {wbs_adr_i[15:1], (wbs_sel_i == 2'b10) ? 1'b1 : wbs_adr_i[0]};
                dat_q  <= wbs_dat_i;
                we_q   <= wbs_we_i;
                byte_q <= (wbs_sel_i == 2'b01) || (wbs_sel_i == 2'b10);
            end

            if (state_q == S_RUN && state_d == S_END && !we_q)
                rdata_q <= qb_ad_i;

            if (state_q == S_IDLE)
                rply_low_q <= 1'b0;
            else if ((state_q == S_SYN || state_q == S_DAT || state_q == S_RUN) && !srply_q)
                rply_low_q <= 1'b1;

            if (state_q == S_IDLE)
                abort_q <= 1'b0;
            else if (!wbs_cyc_i)
                abort_q <= 1'b1;
        end
    end

`ifdef WB_QBUS_INIT_TIMEOUT_EN
    always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
        if (!vm_rst_n) begin
            tmo_cnt_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == S_RUN || state_q == S_END)
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            else
                tmo_cnt_q <= 16'd0;
            err_q <= tmo_hit && wbs_cyc_i && !abort_q;
        end
    end
    assign wbs_err_o = err_q;
`else
    assign wbs_err_o = 1'b0;
`endif

    // ---------------- outputs ----------------
    // Decoded from the state register so reset clears them immediately.
    always_comb begin
        qb_ad_o  = 16'h0000;
        qb_ad_oe = 1'b0;
        qb_sync  = 1'b0;
        qb_din   = 1'b0;
        qb_dout  = 1'b0;
        qb_wtbt  = 1'b0;
        case (state_q)
            S_ADR, S_SYN: begin
                qb_ad_o  = adr_q;
                qb_ad_oe = 1'b1;
                qb_wtbt  = we_q;
                qb_sync  = (state_q == S_SYN);
            end
            S_DAT, S_RUN, S_END: begin
                qb_sync = 1'b1;
                if (we_q) begin
                    qb_ad_o  = dat_q;
                    qb_ad_oe = 1'b1;
                    qb_wtbt  = byte_q;
                end
                if (state_q == S_RUN) begin
                    qb_din  = !we_q;
                    qb_dout = we_q;
                end
            end
            default: ;
        endcase
    end

    assign wbs_ack_o = (state_q == S_ACK) && wbs_cyc_i && !abort_q;
    assign wbs_dat_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_qbus_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_qbus_init
// Purpose  : Directed self-checking bench for wb_qbus_init (TSET=2, TMO=16).
//            A Wishbone master and a simple Q-bus slave are modelled here;
//            expected cycle numbers are hand-derived with cycle 1 being the
//            clock on which the request is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_qbus_init;

    localparam int P_TSET = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [15:0] adr = 16'h0000, wdat = 16'h0000, ad_in = 16'h0000;
    logic        rply = 1'b0;
    logic [15:0] dat_o, ad_o;
    logic        ack, err, ad_oe, sync, din, dout, wtbt;

    always #5 clk = ~clk;

    wb_qbus_init #(.TSET(P_TSET), .TMO(16)) dut (
        .vm_clk_p (clk),   .vm_rst_n (rst_n),
        .wbs_cyc_i(cyc),   .wbs_stb_i(stb),   .wbs_we_i(we),
        .wbs_sel_i(sel),   .wbs_adr_i(adr),   .wbs_dat_i(wdat),
        .wbs_dat_o(dat_o), .wbs_ack_o(ack),   .wbs_err_o(err),
        .qb_ad_o  (ad_o),  .qb_ad_oe (ad_oe), .qb_ad_i  (ad_in),
        .qb_sync  (sync),  .qb_din   (din),   .qb_dout  (dout),
        .qb_wtbt  (wtbt),  .qb_rply_i(rply)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observations of the last transaction
    int          r_ack, r_err, r_both, r_first_sync, r_first_strb, r_strb_cnt, r_done;
    logic [15:0] r_addr, r_wdat;
    logic        r_wtbt_adr, r_wtbt_dat, r_oe_dat, r_qlow;

    function automatic logic qbus_idle();
        return {sync, din, dout, wtbt, ad_oe} == 5'b0 && ad_o == 16'h0000;
    endfunction

    // One Wishbone request with a Q-bus slave answering 'delay' clocks after
    // the first DIN/DOUT. 'stale' > 0 holds RPLY high from before the request
    // until that cycle. 'drop_at' > 0 drops cyc/stb on that cycle.
    task automatic run_txn(input logic t_we, input logic [1:0] t_sel,
                           input logic [15:0] t_adr, input logic [15:0] t_dat,
                           input logic [15:0] t_rd, input int delay,
                           input int stale, input int drop_at, input int budget);
        bit sync_prev = 1'b0;
        bit replied   = 1'b0;
        r_ack = 0; r_err = 0; r_both = 0; r_first_sync = -1; r_first_strb = -1;
        r_strb_cnt = 0; r_done = -1; r_addr = 16'h0; r_wdat = 16'h0;
        r_wtbt_adr = 1'b0; r_wtbt_dat = 1'b0; r_oe_dat = 1'b0; r_qlow = 1'b0;
        ad_in = t_rd;
        if (stale > 0) begin
            rply = 1'b1;
            repeat (3) @(negedge clk);
        end
        cyc = 1'b1; stb = 1'b1; we = t_we; sel = t_sel; adr = t_adr; wdat = t_dat;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin r_addr = ad_o; r_wtbt_adr = wtbt; end
            if (c == 1 + 2 * P_TSET) begin r_wtbt_dat = wtbt; r_wdat = ad_o; r_oe_dat = ad_oe; end
            if (sync && r_first_sync < 0) r_first_sync = c;
            if (din || dout) begin
                r_strb_cnt++;
                if (r_first_strb < 0) r_first_strb = c;
            end
            if (ack) r_ack++;
            if (err) r_err++;
            if (ack && err) r_both++;
            if (sync_prev && !sync && r_done < 0) begin
                r_done = c;
                r_qlow = qbus_idle();
            end
            sync_prev = sync;
            if (ack || err || c == drop_at) begin cyc = 1'b0; stb = 1'b0; end
            // Q-bus slave
            if (c < stale)
                rply = 1'b1;
            else if (stale > 0 && c == stale)
                rply = 1'b0;
            else if (r_first_strb >= 0 && !rply && !replied && c - r_first_strb >= delay) begin
                rply = 1'b1;
                replied = 1'b1;
            end else if (rply && replied && !din && !dout)
                rply = 1'b0;
            if (r_done >= 0 && c >= r_done + 4) break;
        end
        check("txn_completed", (r_done >= 0), 1);
        cyc = 1'b0; stb = 1'b0; rply = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_qbus_low", qbus_idle(), 1);
        check("rst_ack_err", {ack, err}, 2'b00);
        check("rst_dat_o", dat_o, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- word read, adr 16'o001000, RPLY 5 clocks after DIN ----
        run_txn(1'b0, 2'b11, 16'o001000, 16'h0, 16'h1234, 5, 0, 0, 100);
        check("rd_addr", r_addr, 16'o001000);
        check("rd_wtbt_adr", r_wtbt_adr, 0);
        check("rd_first_sync", r_first_sync, 3);
        check("rd_oe_dat", r_oe_dat, 0);
        check("rd_first_din", r_first_strb, 7);
        check("rd_din_len", r_strb_cnt, 8);
        check("rd_ack_cycle", r_done, 18);
        check("rd_ack_cnt", r_ack, 1);
        check("rd_err_cnt", r_err, 0);
        check("rd_qlow_end", r_qlow, 1);
        check("rd_dat_o", dat_o, 16'h1234);

        // ---- byte write, upper lane, adr 16'o002000 ----
        run_txn(1'b1, 2'b10, 16'o002000, 16'hAB00, 16'h0, 3, 0, 0, 100);
        check("bw_addr", r_addr, 16'o002001);
        check("bw_wtbt_adr", r_wtbt_adr, 1);
        check("bw_wtbt_dat", r_wtbt_dat, 1);
        check("bw_wdat", r_wdat, 16'hAB00);
        check("bw_dout_len", r_strb_cnt, 6);
        check("bw_ack_cycle", r_done, 16);
        check("bw_ack_cnt", r_ack, 1);
        check("bw_dat_o_kept", dat_o, 16'h1234);

        // ---- word write ----
        run_txn(1'b1, 2'b11, 16'h0102, 16'h5A5A, 16'h0, 1, 0, 0, 100);
        check("ww_addr", r_addr, 16'h0102);
        check("ww_wtbt_adr", r_wtbt_adr, 1);
        check("ww_wtbt_dat", r_wtbt_dat, 0);
        check("ww_wdat", r_wdat, 16'h5A5A);
        check("ww_ack_cycle", r_done, 14);
        check("ww_ack_cnt", r_ack, 1);

        // ---- byte read, lower lane at odd address keeps bit0 ----
        run_txn(1'b0, 2'b01, 16'h0203, 16'h0, 16'h00C3, 0, 0, 0, 100);
        check("br_addr", r_addr, 16'h0203);
        check("br_din_len", r_strb_cnt, 3);
        check("br_ack_cycle", r_done, 13);
        check("br_dat_o", dat_o, 16'h00C3);

        // ---- stale RPLY high at request start ----
        run_txn(1'b0, 2'b11, 16'h0206, 16'h0, 16'h5555, 2, 12, 0, 100);
        check("st_din_len", r_strb_cnt, 9);
        check("st_ack_cycle", r_done, 19);
        check("st_ack_cnt", r_ack, 1);
        check("st_dat_o", dat_o, 16'h5555);

        // ---- cyc dropped during SYN: cycle completes, no ack ----
        run_txn(1'b0, 2'b11, 16'h0208, 16'h0, 16'h7777, 2, 0, 4, 100);
        check("cd_din_len", r_strb_cnt, 5);
        check("cd_end_cycle", r_done, 15);
        check("cd_ack_cnt", r_ack, 0);
        check("cd_err_cnt", r_err, 0);

`ifdef WB_QBUS_INIT_TIMEOUT_EN
        // ---- no RPLY, timeout after 16 clocks of RUN ----
        run_txn(1'b0, 2'b11, 16'h0300, 16'h0, 16'h9999, 1000, 0, 0, 60);
        check("to_err_cycle", r_done, 23);
        check("to_err_cnt", r_err, 1);
        check("to_ack_cnt", r_ack, 0);
        check("to_qlow", r_qlow, 1);
        check("to_dat_o_kept", dat_o, 16'h7777);
`else
        // ---- no RPLY without timeout: waits indefinitely, never errors ----
        begin
            int errs = 0;
            cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 16'h0300;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (err) errs++;
            end
            check("nt_din_held", {sync, din}, 2'b11);
            check("nt_err_cnt", errs, 0);
            rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
`endif

        // ---- reset during RUN of a write ----
        begin
            int hits = 0;
            cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 16'h0400; wdat = 16'h1111;
            for (int c = 1; c <= 9; c++) @(negedge clk);
            check("rr_dout_before", dout, 1);
            rst_n = 1'b0;
            cyc = 1'b0; stb = 1'b0;
            #1;
            check("rr_qlow_now", qbus_idle(), 1);
            check("rr_ack_err_now", {ack, err}, 2'b00);
            check("rr_dat_o_now", dat_o, 16'h0000);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (ack || err || !qbus_idle()) hits++;
            end
            check("rr_quiet_after", hits, 0);
        end
        run_txn(1'b0, 2'b11, 16'h0208, 16'h0, 16'hBEEF, 2, 0, 0, 100);
        check("rr_next_ack_cycle", r_done, 15);
        check("rr_next_ack_cnt", r_ack, 1);
        check("rr_next_dat_o", dat_o, 16'hBEEF);
        check("ack_err_never_both", r_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/wb_qbus_init.md
WB_QBUS_INIT -- requirements
Module: wb_qbus_init

Interface
REQ-001 The block SHALL have parameter TSET, default 2, meaning phase setup/hold length in clocks (legal range 1..15).
REQ-002 The block SHALL have parameter TMO, default 1023, meaning RPLY timeout in clocks (legal range 16..65535).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset.
- vm_clk_p  in  1  positive clock; all state changes on its rising edge.
- vm_rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these Wishbone slave ports:
- wbs_cyc_i  in  1  cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write.
- wbs_sel_i  in  2  byte lanes.
- wbs_adr_i  in  16  byte address.
- wbs_dat_i  in  16  write data.
- wbs_dat_o  out  16  read data.
- wbs_ack_o  out  1  acknowledge.
- wbs_err_o  out  1  bus error (timeout).
REQ-005 The block SHALL have these Q-bus initiator ports, active-high; pad inversion is external:
- qb_ad_o  out  16  AD drive value.
- qb_ad_oe  out  1  AD output enable.
- qb_ad_i  in  16  AD sampled value.
- qb_sync  out  1  SYNC.
- qb_din  out  1  DIN.
- qb_dout  out  1  DOUT.
- qb_wtbt  out  1  WTBT.
- qb_rply_i  in  1  RPLY, asynchronous.

Function
REQ-006 qb_rply_i SHALL pass through a 2-flop synchronizer; only the synchronized RPLY (srply) is used.
REQ-007 FSM states SHALL be IDLE, ADR, SYN, DAT, RUN, END, ACK; all counts below are clocks of vm_clk_p.
REQ-008 IDLE: on wbs_cyc_i & wbs_stb_i, latch adr/dat/we/sel and enter ADR.
- Latched address bit0 = 1 when sel==2'b10, else wbs_adr_i[0].
- Byte cycle = sel is 01 or 10.
REQ-009 ADR (TSET clocks): qb_ad_oe=1, qb_ad_o=address, qb_wtbt=we, SYNC/DIN/DOUT low.
REQ-010 SYN (TSET clocks): as ADR plus qb_sync=1.
REQ-011 DAT (TSET clocks), qb_sync held:
- Read: qb_ad_oe=0, qb_wtbt=0.
- Write: qb_ad_o=data, qb_ad_oe=1, qb_wtbt=byte cycle.
REQ-012 RUN: qb_din=1 (read) or qb_dout=1 (write) until srply=1.
- On srply, read SHALL latch qb_ad_i into wbs_dat_o.
- Then enter END with DIN/DOUT low.
REQ-013 END: hold qb_sync (and write data) until srply=0, then drop qb_sync and qb_ad_oe and enter ACK.
REQ-014 ACK: wbs_ack_o=1 for exactly one clock, then IDLE; a new request is accepted no earlier than the clock after ACK.
REQ-015 wbs_dat_o SHALL hold its value until the next read latch; on writes wbs_dat_o is unchanged.
REQ-016 If wbs_cyc_i drops after IDLE, the Q-bus cycle SHALL complete normally and wbs_ack_o/wbs_err_o SHALL be suppressed.
REQ-017 srply already high on IDLE exit SHALL NOT be taken as a reply; RUN requires srply to be seen low at least once after entering SYN.
REQ-018 wbs_ack_o and wbs_err_o SHALL never be asserted together.

Reset
REQ-019 Asserting vm_rst_n=0 SHALL asynchronously force FSM=IDLE and clear counters and the synchronizer, in any state.
REQ-020 Reset values:
- qb_sync, qb_din, qb_dout, qb_wtbt, qb_ad_oe, wbs_ack_o, wbs_err_o = 0.
- qb_ad_o, wbs_dat_o = 16'h0000.
A Q-bus cycle in progress SHALL be abandoned without ack/err.

Configuration
REQ-021 Macro WB_QBUS_INIT_TIMEOUT_EN: when defined, a counter SHALL run in RUN and END.
- Reaching TMO SHALL drop SYNC/DIN/DOUT/WTBT/ad_oe in that clock, pulse wbs_err_o one clock, and return to IDLE.
- Read data is not latched on timeout.
REQ-022 Without WB_QBUS_INIT_TIMEOUT_EN the block SHALL wait for RPLY indefinitely and wbs_err_o SHALL be tied 0.

Verification
REQ-023 Word read, adr=16'o001000, TSET=2, RPLY asserted 5 clocks after DIN with AD=16'h1234 -> sync high from ADR+2, din high, wbs_dat_o=16'h1234, single ack after RPLY negated.
REQ-024 Byte write, sel=2'b10, adr=16'o002000, dat=16'hAB00 -> AD address 16'o002001, WTBT=1 in ADR and in DAT, DOUT pulse, one ack.
REQ-025 Timeout enabled, TMO=16, no RPLY -> wbs_err_o one clock at RUN entry+16, all Q-bus outputs low, next request accepted.
REQ-026 vm_rst_n pulsed low during RUN of a write -> all outputs 0 immediately, no ack/err, following read completes normally.
REQ-027 Stale RPLY held high from a prior cycle at request start -> no DIN/DOUT completion until RPLY seen low, then normal ack.
REQ-028 wbs_cyc_i dropped during SYN -> Q-bus cycle completes, no ack.
